// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI window processor: coordinate width, counter
// saturation value, window configuration record and its reset (full passthrough).
package hdmi_pkg;

    localparam int CW = 12;

    typedef logic [CW-1:0] coord_t;

    localparam coord_t CNT_MAX = '1;

    localparam logic SHADOW_INV_RST = 1'b0;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t w;
        coord_t h;
    } win_cfg_t;

    function automatic win_cfg_t win_reset(input coord_t h_act, input coord_t v_act);
        win_cfg_t cfg;
        cfg.x0 = '0;
        cfg.y0 = '0;
        cfg.w  = h_act;
        cfg.h  = v_act;
        return cfg;
    endfunction

    function automatic coord_t sat_inc(input coord_t v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hdmi_timing_meas.sv
// Pixel/line counters derived from de/vs, plus per-frame size measurement
// latched at each vs rising edge (the first one after reset is ignored).
module hdmi_timing_meas
    import hdmi_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 720
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   vs_i,
    input  logic   de_i,
    output coord_t h_cnt_o,
    output coord_t v_cnt_o,
    output logic   vs_rise_o,
    output logic   synced_o,
    output coord_t meas_width_o,
    output coord_t meas_height_o,
    output logic   meas_valid_o
);

    localparam coord_t H_ACT_C = coord_t'(H_ACT);
    localparam coord_t V_ACT_C = coord_t'(V_ACT);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    coord_t max_w_q, max_w_d;
    coord_t meas_w_q, meas_w_d;
    coord_t meas_h_q, meas_h_d;
    coord_t frame_h;
    logic   lines_ok_q, lines_ok_d;
    logic   meas_v_q, meas_v_d;
    logic   vs_prev_q, de_prev_q, synced_q;
    logic   vs_rise, de_fall;

    assign vs_rise = vs_i & ~vs_prev_q;
    assign de_fall = de_prev_q & ~de_i;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        h_cnt_d    = de_i ? sat_inc(h_cnt_q) : '0;
        v_cnt_d    = v_cnt_q;
        max_w_d    = max_w_q;
        lines_ok_d = lines_ok_q;
        meas_w_d   = meas_w_q;
        meas_h_d   = meas_h_q;
        meas_v_d   = meas_v_q;
        frame_h    = de_fall ? sat_inc(v_cnt_q) : v_cnt_q;

        // h_cnt_q holds the finished line's pixel count on the falling edge
        if (de_fall) begin
            if (h_cnt_q > max_w_q) max_w_d = h_cnt_q;
            lines_ok_d = lines_ok_q & (h_cnt_q == H_ACT_C);
        end

        if (vs_rise) begin
            v_cnt_d = '0;
            if (synced_q) begin
                meas_w_d = max_w_d;
                meas_h_d = frame_h;
                meas_v_d = lines_ok_d & (frame_h == V_ACT_C);
            end
            max_w_d    = '0;
            lines_ok_d = 1'b1;
        end else if (de_fall) begin
            v_cnt_d = sat_inc(v_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (rst_i) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            max_w_q    <= '0;
            lines_ok_q <= 1'b1;
            meas_w_q   <= '0;
            meas_h_q   <= '0;
            meas_v_q   <= 1'b0;
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            synced_q   <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            max_w_q    <= max_w_d;
            lines_ok_q <= lines_ok_d;
            meas_w_q   <= meas_w_d;
            meas_h_q   <= meas_h_d;
            meas_v_q   <= meas_v_d;
            vs_prev_q  <= vs_i;
            de_prev_q  <= de_i;
            synced_q   <= synced_q | vs_rise;
        end
    end

    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;
    assign vs_rise_o     = vs_rise;
    assign synced_o      = synced_q;
    assign meas_width_o  = meas_w_q;
    assign meas_height_o = meas_h_q;
    assign meas_valid_o  = meas_v_q;

endmodule

// File: rtl/hdmi_win_proc.sv
// Windowed video pass-through: pixels outside a tear-free shadowed window become
// BG_COLOR, 2-cycle aligned latency. Define HDMI_WIN_INVERT_EN for colour invert.
module hdmi_win_proc
    import hdmi_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 720,
    parameter int NCH   = 3,
    parameter int DW    = 8,
    parameter logic [NCH*DW-1:0] BG_COLOR = '0
) (
    input  logic              pixclk_in,
    input  logic              rst_i,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [CW-1:0]     win_x0,
    input  logic [CW-1:0]     win_y0,
    input  logic [CW-1:0]     win_w,
    input  logic [CW-1:0]     win_h,
    input  logic              invert_ctrl,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [NCH*DW-1:0] data_out,
    output logic [CW-1:0]     meas_width,
    output logic [CW-1:0]     meas_height,
    output logic              meas_valid
);

    localparam int           PW      = NCH * DW;
    localparam logic [CW:0]  H_LIM   = (CW+1)'(H_ACT);
    localparam logic [CW:0]  V_LIM   = (CW+1)'(V_ACT);
    localparam win_cfg_t     CFG_RST = win_reset(coord_t'(H_ACT), coord_t'(V_ACT));

    win_cfg_t    cfg_in, cfg_s1_q, cfg_s2_q, shadow_q;
    coord_t      h_cnt, v_cnt;
    logic        vs_rise, synced;
    logic [CW:0] x_end, y_end, x_lim, y_lim;
    logic        in_win;
    logic [PW-1:0] pix_in, pix_d;
    logic [PW-1:0] pix1_q, pix2_q;
    logic        vs1_q, hs1_q, de1_q, vs2_q, hs2_q, de2_q;

    assign cfg_in = '{x0: win_x0, y0: win_y0, w: win_w, h: win_h};

    // Config crosses in through two flops, then only moves into the shadow at frame start
    always_ff @(posedge pixclk_in) begin
        if (rst_i) begin
            cfg_s1_q <= CFG_RST;
            cfg_s2_q <= CFG_RST;
            shadow_q <= CFG_RST;
        end else begin
            cfg_s1_q <= cfg_in;
            cfg_s2_q <= cfg_s1_q;
            if (vs_rise) shadow_q <= cfg_s2_q;
        end
    end

`ifdef HDMI_WIN_INVERT_EN
    logic inv_s1_q, inv_s2_q, inv_q;

    always_ff @(posedge pixclk_in) begin
        if (rst_i) begin
            inv_s1_q <= SHADOW_INV_RST;
            inv_s2_q <= SHADOW_INV_RST;
            inv_q    <= SHADOW_INV_RST;
        end else begin
            inv_s1_q <= invert_ctrl;
            inv_s2_q <= inv_s1_q;
            if (vs_rise) inv_q <= inv_s2_q;
        end
    end

    assign pix_in = data_in ^ {PW{inv_q}};
`else
    logic unused_invert;
    assign unused_invert = invert_ctrl;
    assign pix_in        = data_in;
`endif

    hdmi_timing_meas #(
        .H_ACT(H_ACT),
        .V_ACT(V_ACT)
    ) u_timing (
        .clk_i        (pixclk_in),
        .rst_i        (rst_i),
        .vs_i         (vs_in),
        .de_i         (de_in),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .vs_rise_o    (vs_rise),
        .synced_o     (synced),
        .meas_width_o (meas_width),
        .meas_height_o(meas_height),
        .meas_valid_o (meas_valid)
    );

    // 13-bit window ends cannot overflow; clipping to the active area removes wrap artifacts
    always_comb begin
        x_end  = {1'b0, shadow_q.x0} + {1'b0, shadow_q.w};
        y_end  = {1'b0, shadow_q.y0} + {1'b0, shadow_q.h};
        x_lim  = (x_end > H_LIM) ? H_LIM : x_end;
        y_lim  = (y_end > V_LIM) ? V_LIM : y_end;
        in_win = synced
               && (h_cnt >= shadow_q.x0) && ({1'b0, h_cnt} < x_lim)
               && (v_cnt >= shadow_q.y0) && ({1'b0, v_cnt} < y_lim);
        pix_d  = '0;
        if (de_in) pix_d = in_win ? pix_in : BG_COLOR;
    end

    always_ff @(posedge pixclk_in) begin
        if (rst_i) begin
            vs1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            de1_q  <= 1'b0;
            pix1_q <= '0;
            vs2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            de2_q  <= 1'b0;
            pix2_q <= '0;
        end else begin
            vs1_q  <= vs_in;
            hs1_q  <= hs_in;
            de1_q  <= de_in;
            pix1_q <= pix_d;
            vs2_q  <= vs1_q;
            hs2_q  <= hs1_q;
            de2_q  <= de1_q;
            pix2_q <= pix1_q;
        end
    end

    assign vs_out   = vs2_q;
    assign hs_out   = hs2_q;
    assign de_out   = de2_q;
    assign data_out = pix2_q;

endmodule

// File: tb/tb_hdmi_win_proc.sv
// Self-checking bench for hdmi_win_proc on a reduced 64x24 raster: every output
// cycle is compared with a pixel-coordinate reference model; frame sizes from a table.
module tb_hdmi_win_proc;

    localparam int          H_T  = 64;
    localparam int          V_T  = 24;
    localparam logic [23:0] BG_T = 24'h5A0F3C;
`ifdef HDMI_WIN_INVERT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic        pixclk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [23:0] din = '0;
    logic [11:0] wx0, wy0, ww, wh;
    logic        inv;
    logic        vs_o, hs_o, de_o, mv;
    logic [23:0] dout;
    logic [11:0] mw, mh;

    always #5 pixclk = ~pixclk;

    hdmi_win_proc #(
        .H_ACT(H_T), .V_ACT(V_T), .NCH(3), .DW(8), .BG_COLOR(BG_T)
    ) dut (
        .pixclk_in(pixclk), .rst_i(rst),
        .vs_in(vs), .hs_in(hs), .de_in(de), .data_in(din),
        .win_x0(wx0), .win_y0(wy0), .win_w(ww), .win_h(wh), .invert_ctrl(inv),
        .vs_out(vs_o), .hs_out(hs_o), .de_out(de_o), .data_out(dout),
        .meas_width(mw), .meas_height(mh), .meas_valid(mv)
    );

    typedef struct { int x0, y0, w, h; bit inv; } win_t;
    typedef struct packed { logic vs, hs, de; logic [23:0] d; } px_t;
    typedef struct {
        int x0, y0, w, h; bit inv;
        int nl, short_ln, long_ln, chg_ln, chg_x0; bit fixed;
        int emw, emh; bit emv;
    } fvec_t;

    int   n_chk = 0, n_err = 0;
    win_t cur_win;
    bit   m_sync, f_ok, e_mv;
    int   f_lines, f_maxw, e_mw, e_mh;
    px_t  q[$];
    fvec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Expected output for one driven cycle, from the window rules and pixel coordinates
    function automatic px_t model_px(input logic v, input logic h, input logic d_en,
                                     input logic [23:0] d, input int x, input int y);
        px_t r;
        int  xe, ye;
        bit  in_w;
        r.vs = v; r.hs = h; r.de = d_en; r.d = '0;
        if (d_en) begin
            xe = cur_win.x0 + cur_win.w; if (xe > H_T) xe = H_T;
            ye = cur_win.y0 + cur_win.h; if (ye > V_T) ye = V_T;
            in_w = m_sync && x >= cur_win.x0 && x < xe && y >= cur_win.y0 && y < ye;
            if (!in_w)                     r.d = BG_T;
            else if (INV_EN && cur_win.inv) r.d = ~d;
            else                           r.d = d;
        end
        return r;
    endfunction

    function automatic void model_reset();
        cur_win = '{0, 0, H_T, V_T, 1'b0};
        m_sync = 1'b0;
        f_lines = 0; f_maxw = 0; f_ok = 1'b1;
        e_mw = 0; e_mh = 0; e_mv = 1'b0;
    endfunction

    function automatic void frame_start();
        if (m_sync) begin
            e_mw = f_maxw; e_mh = f_lines; e_mv = f_ok && (f_lines == V_T);
        end
        m_sync = 1'b1;
        cur_win = '{int'(wx0), int'(wy0), int'(ww), int'(wh), inv};
        f_lines = 0; f_maxw = 0; f_ok = 1'b1;
    endfunction

    function automatic void line_end(input int len);
        f_lines++;
        if (len > f_maxw) f_maxw = len;
        if (len != H_T) f_ok = 1'b0;
    endfunction

    task automatic step(input logic v, input logic h, input logic d_en,
                        input logic [23:0] d, input int x, input int y);
        px_t e;
        vs = v; hs = h; de = d_en; din = d;
        q.push_back(model_px(v, h, d_en, d, x, y));
        @(posedge pixclk);
        @(negedge pixclk);
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("px", 64'({vs_o, hs_o, de_o, dout}), 64'(e));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    endtask

    task automatic line_head(input int y);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 24'($urandom), 0, y);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, y);
    endtask

    task automatic line(input int len, input int y, input bit fixed, input bit tail);
        line_head(y);
        for (int x = 0; x < len; x++)
            step(1'b0, 1'b0, 1'b1, fixed ? 24'h123456 : 24'($urandom), x, y);
        line_end(len);
        if (tail) for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, y);
    endtask

    // Frame start; measurement of the previous frame is checked shortly after the vs rise
    task automatic vsync(input bit use_model, input int emw, input int emh, input bit emv,
                         input string name);
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
        frame_start();
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
        if (use_model) check(name, 64'({mw, mh, mv}), 64'({12'(e_mw), 12'(e_mh), e_mv}));
        else           check(name, 64'({mw, mh, mv}), 64'({12'(emw), 12'(emh), emv}));
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
        idle(4);
    endtask

    task automatic set_cfg(input int x0, input int y0, input int w, input int h, input bit iv);
        wx0 = 12'(x0); wy0 = 12'(y0); ww = 12'(w); wh = 12'(h); inv = iv;
    endtask

    task automatic run_frame(input fvec_t f);
        int len;
        for (int y = 0; y < f.nl; y++) begin
            if (y == f.chg_ln) wx0 = 12'(f.chg_x0);
            len = (y == f.short_ln) ? H_T - 1 : (y == f.long_ln) ? H_T + 1 : H_T;
            line(len, y, f.fixed, 1'b1);
        end
    endtask

    initial begin
        //            x0  y0   w    h  inv nl  shrt long chg chgx fix  mw  mh  mv
        tbl[0] = '{10,  5,  16,   8, 0, 24, -1, -1, -1,  0, 0, 64, 24, 1};
        tbl[1] = '{10,  5,  16,   8, 0, 24, -1, -1,  9, 30, 0, 64, 24, 1};
        tbl[2] = '{30,  5,  16,   8, 0, 24, -1, -1, -1,  0, 0, 64, 24, 1};
        tbl[3] = '{56, 20, 100, 100, 0, 24, -1, -1, -1,  0, 0, 64, 24, 1};
        tbl[4] = '{ 0,  0,   0,  24, 0, 24, -1, -1, -1,  0, 0, 64, 24, 1};
        tbl[5] = '{ 0,  0,  64,  24, 0, 24,  7, -1, -1,  0, 0, 64, 24, 0};
        tbl[6] = '{ 0,  0,  64,  24, 0, 24, -1, -1, -1,  0, 0, 64, 24, 1};
        tbl[7] = '{10,  5,  16,   8, 1, 24, -1, -1, -1,  0, 1, 64, 24, 1};
        tbl[8] = '{ 0,  0,  64,  24, 0, 23, -1, -1, -1,  0, 0, 64, 23, 0};
        tbl[9] = '{ 3,  2,   4,   4, 0, 24, -1,  4, -1,  0, 0, 65, 24, 0};

        set_cfg(0, 0, H_T, V_T, 1'b0);
        model_reset();
        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        check("reset_state", 64'({vs_o, hs_o, de_o, dout, mw, mh, mv}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_cfg(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].inv);
            idle(4);
            if (i == 0) vsync(1'b1, 0, 0, 1'b0, "meas_first_edge");
            else        vsync(1'b0, tbl[i-1].emw, tbl[i-1].emh, tbl[i-1].emv, "meas_tbl");
            run_frame(tbl[i]);
        end
        idle(4);
        vsync(1'b0, tbl[9].emw, tbl[9].emh, tbl[9].emv, "meas_tbl_last");

        // vs rise on the same cycle as the last line's de fall: next frame restarts at line 0
        set_cfg(0, 0, H_T, 2, 1'b0);
        idle(4);
        vsync(1'b1, 0, 0, 1'b0, "meas_pre_coincide");
        for (int y = 0; y < V_T; y++) line(H_T, y, 1'b0, y != V_T - 1);
        vsync(1'b1, 0, 0, 1'b0, "meas_coincide");
        for (int y = 0; y < V_T; y++) line(H_T, y, 1'b0, 1'b1);
        idle(4);
        vsync(1'b1, 0, 0, 1'b0, "meas_post_coincide");

        for (int r = 0; r < 4; r++) begin
            set_cfg($urandom_range(70), $urandom_range(30), $urandom_range(70),
                    $urandom_range(30), 1'($urandom_range(1)));
            idle(4);
            vsync(1'b1, 0, 0, 1'b0, "meas_rand");
            for (int y = 0; y < (($urandom_range(5) == 0) ? V_T - 1 : V_T); y++) begin
                int len;
                len = H_T;
                if ($urandom_range(7) == 0) len = ($urandom_range(1) == 1) ? H_T + 1 : H_T - 1;
                line(len, y, 1'b0, 1'b1);
            end
        end
        idle(4);
        vsync(1'b1, 0, 0, 1'b0, "meas_rand_last");

        // Reset in the middle of line 10, then recovery at the next frame start
        set_cfg(0, 0, H_T, V_T, 1'b0);
        idle(4);
        vsync(1'b1, 0, 0, 1'b0, "meas_pre_rst");
        for (int y = 0; y < 10; y++) line(H_T, y, 1'b0, 1'b1);
        line_head(10);
        for (int x = 0; x < 5; x++) step(1'b0, 1'b0, 1'b1, 24'($urandom), x, 10);
        rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b1; din = 24'($urandom);
        @(posedge pixclk);
        @(negedge pixclk);
        check("rst_outputs", 64'({vs_o, hs_o, de_o, dout, mw, mh, mv}), 64'(0));
        rst = 1'b0;
        model_reset();
        q.delete();
        q.push_back(px_t'('0));
        for (int x = 5; x < H_T; x++) step(1'b0, 1'b0, 1'b1, 24'($urandom), x, 10);
        line_end(H_T - 5);
        for (int y = 11; y < V_T; y++) line(H_T, y, 1'b0, 1'b1);
        idle(4);
        vsync(1'b1, 0, 0, 1'b0, "meas_after_rst");
        for (int y = 0; y < V_T; y++) line(H_T, y, 1'b0, 1'b1);
        idle(4);
        vsync(1'b1, 0, 0, 1'b0, "meas_rst_recover");
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
